// File: rtl/ctrl_flujo_param_pkg.sv
// Shared definitions for the flow-control block: state codes and default widths.
package ctrl_flujo_param_pkg;

   localparam int UMB_W_DEF = 3;
   localparam int CNT_W_DEF = 5;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } estado_t;

   // Pops only count while the fabric is configured and healthy.
   function automatic logic cuenta_habilitada(input estado_t s);
      return (s == ST_IDLE) || (s == ST_ACTIVE);
   endfunction

endpackage

// File: rtl/ctrl_flujo_param_banco_contadores.sv
// Per-output-channel pop counters with registered indexed readback and optional clear-on-read.
module ctrl_flujo_param_banco_contadores #(
   parameter int NUM_OUT     = 4,
   parameter int IDX_W       = 2,
   parameter int CNT_W       = 5,
   parameter int CLR_ON_READ = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [NUM_OUT-1:0] pop_out,
   input  logic               req_ok,
   input  logic [IDX_W-1:0]   idx,
   output logic               valid_contador,
   output logic [CNT_W-1:0]   contador_out
);

   logic [CNT_W-1:0]   cnt [NUM_OUT];
   logic [NUM_OUT-1:0] inc_v;
   logic [NUM_OUT-1:0] clr_v;
   logic [CNT_W-1:0]   rd_dato;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      inc_v   = '0;
      clr_v   = '0;
      rd_dato = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         inc_v[i] = en & pop_out[i];
         clr_v[i] = (CLR_ON_READ != 0) && req_ok && (idx == IDX_W'(i));
         if (idx == IDX_W'(i)) rd_dato = cnt[i];
      end
   end

   // NOTE: the counter array is a small register file, not a RAM, so it takes the async reset like any flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_OUT; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_OUT; i++) begin
            if (clr_v[i])      cnt[i] <= CNT_W'(inc_v[i]);
            else if (inc_v[i]) cnt[i] <= cnt[i] + CNT_W'(1);
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so reads above see pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_contador <= 1'b0;
         contador_out   <= '0;
      end else begin
         valid_contador <= req_ok;
         contador_out   <= req_ok ? rd_dato : '0;
      end
   end

endmodule

// File: rtl/ctrl_flujo_param.sv
// Flow-control FSM with watermark latching and a bank of readable pop counters.
module ctrl_flujo_param
   import ctrl_flujo_param_pkg::*;
#(
   parameter int NUM_CH      = 8,
   parameter int NUM_OUT     = 4,
   parameter int IDX_W       = 2,
   parameter int UMB_W       = UMB_W_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int CLR_ON_READ = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               init,
   input  logic [UMB_W-1:0]   alto,
   input  logic [UMB_W-1:0]   bajo,
   input  logic [NUM_CH-1:0]  empty_fifos,
   input  logic [NUM_CH-1:0]  error_fifos,
   input  logic [NUM_OUT-1:0] pop_out,
   input  logic [IDX_W-1:0]   idx,
   input  logic               req,
   output logic [UMB_W-1:0]   alto_out,
   output logic [UMB_W-1:0]   bajo_out,
   output logic [2:0]         estado,
   output logic               idle_out,
   output logic               active_out,
   output logic               error_out,
   output logic               valid_contador,
   output logic [CNT_W-1:0]   contador_out
);

   estado_t st, st_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) st <= ST_RESET;
      else        st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      case (st)
         ST_RESET: st_nxt = ST_INIT;
         ST_INIT: begin
            if (!init) st_nxt = (bajo >= alto) ? ST_ERROR : ST_IDLE;
         end
         ST_IDLE, ST_ACTIVE: begin
            if (|error_fifos)      st_nxt = ST_ERROR;
            else if (init)         st_nxt = ST_INIT;
            else if (&empty_fifos) st_nxt = ST_IDLE;
            else                   st_nxt = ST_ACTIVE;
         end
         ST_ERROR: st_nxt = ST_ERROR;
         default:  st_nxt = ST_RESET;
      endcase
   end

   // Thresholds track the inputs throughout INIT and freeze once it is left.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alto_out <= '0;
         bajo_out <= '0;
      end else if (st == ST_INIT) begin
         alto_out <= alto;
         bajo_out <= bajo;
      end
   end

   assign estado     = st;
   assign idle_out   = (st == ST_IDLE);
   assign active_out = (st == ST_ACTIVE);
   assign error_out  = (st == ST_ERROR);

   ctrl_flujo_param_banco_contadores #(
      .NUM_OUT     (NUM_OUT),
      .IDX_W       (IDX_W),
      .CNT_W       (CNT_W),
      .CLR_ON_READ (CLR_ON_READ)
   ) u_banco (
      .clk            (clk),
      .reset          (reset),
      .en             (cuenta_habilitada(st)),
      .pop_out        (pop_out),
      .req_ok         (req && (st == ST_IDLE)),
      .idx            (idx),
      .valid_contador (valid_contador),
      .contador_out   (contador_out)
   );

endmodule

// File: tb/tb_ctrl_flujo_param.sv
// Self-checking bench: two instances (plain, and 3-channel clear-on-read) against a behavioural model.
module tb_ctrl_flujo_param;

   logic       clk = 1'b0;
   logic       reset;
   logic       init;
   logic [2:0] alto, bajo;
   logic [7:0] empty_fifos, error_fifos;
   logic [3:0] pop_out;
   logic [1:0] idx;
   logic       req;

   logic [2:0] alto_a, bajo_a, estado_a, alto_b, bajo_b, estado_b;
   logic       idle_a, active_a, err_a, valid_a, idle_b, active_b, err_b, valid_b;
   logic [4:0] cnt_a, cnt_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ctrl_flujo_param #(.NUM_CH(8), .NUM_OUT(4), .IDX_W(2), .UMB_W(3), .CNT_W(5), .CLR_ON_READ(0)) dut_a (
      .clk(clk), .reset(reset), .init(init), .alto(alto), .bajo(bajo),
      .empty_fifos(empty_fifos), .error_fifos(error_fifos), .pop_out(pop_out),
      .idx(idx), .req(req), .alto_out(alto_a), .bajo_out(bajo_a), .estado(estado_a),
      .idle_out(idle_a), .active_out(active_a), .error_out(err_a),
      .valid_contador(valid_a), .contador_out(cnt_a));

   ctrl_flujo_param #(.NUM_CH(8), .NUM_OUT(3), .IDX_W(2), .UMB_W(3), .CNT_W(5), .CLR_ON_READ(1)) dut_b (
      .clk(clk), .reset(reset), .init(init), .alto(alto), .bajo(bajo),
      .empty_fifos(empty_fifos), .error_fifos(error_fifos), .pop_out(pop_out[2:0]),
      .idx(idx), .req(req), .alto_out(alto_b), .bajo_out(bajo_b), .estado(estado_b),
      .idle_out(idle_b), .active_out(active_b), .error_out(err_b),
      .valid_contador(valid_b), .contador_out(cnt_b));

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_state, m_alto, m_bajo;
   bit m_valid;
   int m_out [2];
   int m_cnt [2][4];
   int n_out [2] = '{4, 3};
   int clr   [2] = '{0, 1};

   function automatic int next_state(input int s);
      case (s)
         0: return 1;
         1: return init ? 1 : ((int'(bajo) >= int'(alto)) ? 4 : 2);
         2, 3: begin
            if (error_fifos != 0) return 4;
            if (init)             return 1;
            return (empty_fifos == 8'hFF) ? 2 : 3;
         end
         default: return 4;
      endcase
   endfunction

   function automatic int new_cnt(input int m, input int i);
      int inc;
      inc = ((m_state == 2 || m_state == 3) && pop_out[i]) ? 1 : 0;
      if (clr[m] != 0 && m_state == 2 && req && int'(idx) == i) return inc;
      return (m_cnt[m][i] + inc) % 32;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_state <= 0; m_alto <= 0; m_bajo <= 0; m_valid <= 1'b0;
         for (int m = 0; m < 2; m++) begin
            m_out[m] <= 0;
            for (int i = 0; i < 4; i++) m_cnt[m][i] <= 0;
         end
      end else begin
         m_state <= next_state(m_state);
         if (m_state == 1) begin
            m_alto <= int'(alto);
            m_bajo <= int'(bajo);
         end
         m_valid <= (m_state == 2) && req;
         for (int m = 0; m < 2; m++) begin
            m_out[m] <= (m_state == 2 && req && int'(idx) < n_out[m]) ? m_cnt[m][idx] : 0;
            for (int i = 0; i < n_out[m]; i++) m_cnt[m][i] <= new_cnt(m, i);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(posedge clk) begin
      #1;
      check("estado_a", int'(estado_a), m_state);
      check("estado_b", int'(estado_b), m_state);
      check("idle_a",   int'(idle_a),   int'(m_state == 2));
      check("active_a", int'(active_a), int'(m_state == 3));
      check("error_a",  int'(err_a),    int'(m_state == 4));
      check("alto_a",   int'(alto_a),   m_alto);
      check("bajo_a",   int'(bajo_a),   m_bajo);
      check("valid_a",  int'(valid_a),  int'(m_valid));
      check("valid_b",  int'(valid_b),  int'(m_valid));
      check("cnt_a",    int'(cnt_a),    m_out[0]);
      check("cnt_b",    int'(cnt_b),    m_out[1]);
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic bring_up(input logic [2:0] a, input logic [2:0] b);
      reset = 1'b0; init = 1'b0; req = 1'b0; pop_out = '0;
      error_fifos = '0; empty_fifos = 8'hFF;
      tick();
      reset = 1'b1; init = 1'b1; alto = a; bajo = b;
      tick(3);
      init = 1'b0;
      tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b0; init = 1'b0; alto = '0; bajo = '0; empty_fifos = 8'hFF;
      error_fifos = '0; pop_out = '0; idx = '0; req = 1'b0;
      tick(2);
      check("rst_estado", int'(estado_a), 0);
      check("rst_alto",   int'(alto_a),   0);
      check("rst_valid",  int'(valid_a),  0);

      // Bring-up: RESET -> INIT -> IDLE with thresholds 6/2
      reset = 1'b1; init = 1'b1; alto = 3'd6; bajo = 3'd2;
      tick();
      check("lit_init", int'(estado_a), 1);
      tick(2);
      init = 1'b0;
      tick();
      check("lit_idle",   int'(estado_a), 2);
      check("lit_alto",   int'(alto_a),   6);
      check("lit_bajo",   int'(bajo_a),   2);
      check("lit_idle_o", int'(idle_a),   1);

      empty_fifos = 8'hFE; tick();
      check("lit_active", int'(estado_a), 3);
      empty_fifos = 8'hFF; tick();
      check("lit_back_idle", int'(estado_a), 2);

      // 33 pops on channel 2 wrap a 5-bit counter to 1
      empty_fifos = 8'hFE; tick();
      pop_out = 4'b0100; tick(33);
      pop_out = '0; empty_fifos = 8'hFF; tick();
      req = 1'b1; idx = 2'd2; tick();
      req = 1'b0;
      check("lit_wrap_valid", int'(valid_a), 1);
      check("lit_wrap_a",     int'(cnt_a),   1);
      check("lit_wrap_b",     int'(cnt_b),   1);

      // Clear-on-read with a simultaneous pop
      pop_out = 4'b0010; tick(7);
      req = 1'b1; idx = 2'd1; tick();
      pop_out = '0;
      check("lit_clr_first_b", int'(cnt_b), 7);
      check("lit_clr_first_a", int'(cnt_a), 7);
      tick();
      check("lit_clr_second_b", int'(cnt_b), 1);
      check("lit_clr_second_a", int'(cnt_a), 8);
      idx = 2'd3; tick();
      check("lit_oob_valid_b", int'(valid_b), 1);
      check("lit_oob_cnt_b",   int'(cnt_b),   0);
      req = 1'b0;

      // req outside IDLE, then error beats init
      empty_fifos = 8'hFE; tick();
      req = 1'b1; tick();
      req = 1'b0;
      check("lit_req_active", int'(valid_a), 0);
      empty_fifos = 8'hFF; tick();
      error_fifos = 8'h20; init = 1'b1; tick();
      check("lit_err_wins", int'(estado_a), 4);
      error_fifos = '0; tick();
      empty_fifos = 8'h00; tick();
      init = 1'b0; tick();
      check("lit_err_sticky", int'(estado_a), 4);

      // bajo >= alto at init exit
      bring_up(3'd3, 3'd3);
      check("lit_bad_umb", int'(estado_a), 4);
      check("lit_bad_err", int'(err_a),    1);

      // Reset pulse while a read is pending
      bring_up(3'd6, 3'd2);
      pop_out = 4'b1111; tick(3);
      pop_out = '0; req = 1'b1; idx = 2'd0;
      #3 reset = 1'b0;
      #1;
      check("lit_rst_mid_estado", int'(estado_a), 0);
      check("lit_rst_mid_valid",  int'(valid_a),  0);
      tick();
      req = 1'b0; reset = 1'b1; init = 1'b1; tick(2);
      init = 1'b0; tick();
      req = 1'b1; idx = 2'd0; tick();
      req = 1'b0;
      check("lit_rst_cnt_valid", int'(valid_a), 1);
      check("lit_rst_cnt_zero",  int'(cnt_a),   0);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         reset       = ($urandom_range(0, 149) != 0);
         init        = ($urandom_range(0, 11) == 0);
         alto        = 3'($urandom);
         bajo        = 3'($urandom);
         empty_fifos = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
         error_fifos = ($urandom_range(0, 199) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
         pop_out     = 4'($urandom);
         idx         = 2'($urandom);
         req         = ($urandom_range(0, 1) != 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
